// File: rtl/uart_dbg_pkg.sv
// -----------------------------------------------------------------------------
// uart_dbg_pkg
// Shared definitions for the UART debug command path:
//   - opcode byte values and the 3-bit command codes they map to
//   - command-sequencer state encoding
//   - field sizes (address / data byte counts)
//   - helpers: decode_opcode, has_addr, has_data
// -----------------------------------------------------------------------------
package uart_dbg_pkg;

  localparam int ADDR_BYTES = 4;
  localparam int DATA_BYTES = 4;
  localparam int ADDR_W     = ADDR_BYTES * 8;
  localparam int DATA_W     = DATA_BYTES * 8;

  // Wide enough to count the longer of the two argument fields.
  localparam int BYTE_CNT_W = (ADDR_BYTES > DATA_BYTES) ? $clog2(ADDR_BYTES)
                                                        : $clog2(DATA_BYTES);

  // Opcode byte values as received on the wire.
  localparam logic [7:0] OPC_PAUSE   = 8'h01;
  localparam logic [7:0] OPC_RESUME  = 8'h02;
  localparam logic [7:0] OPC_MEM_RD  = 8'h03;
  localparam logic [7:0] OPC_MEM_WR  = 8'h04;
  localparam logic [7:0] OPC_REG_RD  = 8'h05;
  localparam logic [7:0] OPC_REG_WR  = 8'h06;
  localparam logic [7:0] OPC_MCU_RST = 8'h07;

  // Decoded command codes presented downstream. OP_NONE marks an
  // unrecognised byte and is never issued.
  typedef enum logic [2:0] {
    OP_NONE    = 3'd0,
    OP_PAUSE   = 3'd1,
    OP_RESUME  = 3'd2,
    OP_MEM_RD  = 3'd3,
    OP_MEM_WR  = 3'd4,
    OP_REG_RD  = 3'd5,
    OP_REG_WR  = 3'd6,
    OP_MCU_RST = 3'd7
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_DATA  = 2'd2,
    ST_ISSUE = 2'd3
  } seq_state_e;

  function automatic cmd_op_e decode_opcode(input logic [7:0] b);
    cmd_op_e op;
    case (b)
      OPC_PAUSE:   op = OP_PAUSE;
      OPC_RESUME:  op = OP_RESUME;
      OPC_MEM_RD:  op = OP_MEM_RD;
      OPC_MEM_WR:  op = OP_MEM_WR;
      OPC_REG_RD:  op = OP_REG_RD;
      OPC_REG_WR:  op = OP_REG_WR;
      OPC_MCU_RST: op = OP_MCU_RST;
      default:     op = OP_NONE;
    endcase
    return op;
  endfunction

  function automatic logic has_addr(input cmd_op_e op);
    return (op == OP_MEM_RD) || (op == OP_MEM_WR) ||
           (op == OP_REG_RD) || (op == OP_REG_WR);
  endfunction

  function automatic logic has_data(input cmd_op_e op);
    return (op == OP_MEM_WR) || (op == OP_REG_WR);
  endfunction

endpackage

// File: rtl/uart_cmd_sequencer_if.sv
// -----------------------------------------------------------------------------
// uart_cmd_sequencer_if
// Bundles the byte-strobe input, the command valid/ready handshake and the
// status/error outputs of the UART command sequencer.
//   master : the sequencer side (consumes bytes + ready, drives command/status)
//   slave  : the surrounding logic (drives bytes + ready, observes command)
// Clock and reset are not part of the bundle.
// -----------------------------------------------------------------------------
interface uart_cmd_sequencer_if;
  import uart_dbg_pkg::*;

  logic              i_Rx_DV;
  logic [7:0]        i_Rx_Byte;
  logic              o_Cmd_Valid;
  logic              i_Cmd_Ready;
  logic [2:0]        o_Cmd_Op;
  logic [ADDR_W-1:0] o_Cmd_Addr;
  logic [DATA_W-1:0] o_Cmd_Data;
  logic              o_Busy;
  logic              o_Err_Opcode;
  logic              o_Err_Timeout;
  logic              o_Err_Overrun;

  modport master (
    input  i_Rx_DV, i_Rx_Byte, i_Cmd_Ready,
    output o_Cmd_Valid, o_Cmd_Op, o_Cmd_Addr, o_Cmd_Data,
    output o_Busy, o_Err_Opcode, o_Err_Timeout, o_Err_Overrun
  );

  modport slave (
    output i_Rx_DV, i_Rx_Byte, i_Cmd_Ready,
    input  o_Cmd_Valid, o_Cmd_Op, o_Cmd_Addr, o_Cmd_Data,
    input  o_Busy, o_Err_Opcode, o_Err_Timeout, o_Err_Overrun
  );

endinterface

// File: rtl/uart_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// uart_cmd_sequencer
// Assembles UART bytes into debug commands: an opcode byte, then optionally
// a 4-byte big-endian address and a 4-byte big-endian data word. The finished
// command is held on a valid/ready handshake until the downstream accepts it.
// Malformed (unknown opcode), stalled (inter-byte timeout) and overrunning
// (byte during ISSUE) frames each raise a one-cycle error pulse.
//
// Ports:
//   i_Clock    system clock
//   i_Reset_n  synchronous active-low reset
//   bus        uart_cmd_sequencer_if.master
//                i_Rx_DV / i_Rx_Byte    byte strobe from the receiver
//                o_Cmd_Valid / i_Cmd_Ready, o_Cmd_Op/Addr/Data  command out
//                o_Busy                 high whenever not IDLE
//                o_Err_Opcode/Timeout/Overrun  one-cycle error pulses
// -----------------------------------------------------------------------------
module uart_cmd_sequencer
  import uart_dbg_pkg::*;
#(
  parameter  int TIMEOUT_CLKS = 100000,
  localparam int TO_CNT_SIZE  = $clog2(TIMEOUT_CLKS)
) (
  input logic                 i_Clock,
  input logic                 i_Reset_n,
  uart_cmd_sequencer_if.master bus
);

  localparam logic [TO_CNT_SIZE-1:0] TO_LAST   = TO_CNT_SIZE'(TIMEOUT_CLKS - 1);
  localparam logic [BYTE_CNT_W-1:0]  ADDR_LAST = BYTE_CNT_W'(ADDR_BYTES - 1);
  localparam logic [BYTE_CNT_W-1:0]  DATA_LAST = BYTE_CNT_W'(DATA_BYTES - 1);

  seq_state_e              state_q, state_d;
  cmd_op_e                 op_q, op_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic [BYTE_CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [TO_CNT_SIZE-1:0]  to_cnt_q, to_cnt_d;
  logic                    err_opcode_q, err_opcode_d;
  logic                    err_timeout_q, err_timeout_d;
  logic                    err_overrun_q, err_overrun_d;

  cmd_op_e rx_op;
  logic    to_expired;

  assign rx_op      = decode_opcode(bus.i_Rx_Byte);
  // Expiry only counts when no byte arrives in the same cycle: the byte wins.
  assign to_expired = (to_cnt_q == TO_LAST) && !bus.i_Rx_DV;

  // ---- state register ----
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_Rx_DV && (rx_op != OP_NONE)) begin
          state_d = has_addr(rx_op) ? ST_ADDR : ST_ISSUE;
        end
      end
      ST_ADDR: begin
        if (bus.i_Rx_DV) begin
          if (byte_cnt_q == ADDR_LAST) begin
            state_d = has_data(op_q) ? ST_DATA : ST_ISSUE;
          end
        end else if (to_expired) begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (bus.i_Rx_DV) begin
          if (byte_cnt_q == DATA_LAST) begin
            state_d = ST_ISSUE;
          end
        end else if (to_expired) begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // o_Cmd_Valid is high for the whole of ISSUE, so ready alone completes it.
        if (bus.i_Cmd_Ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---- output / datapath next-value logic ----
  always_comb begin
    op_d          = op_q;
    addr_d        = addr_q;
    data_d        = data_q;
    byte_cnt_d    = byte_cnt_q;
    to_cnt_d      = to_cnt_q;
    err_opcode_d  = 1'b0;
    err_timeout_d = 1'b0;
    err_overrun_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_Rx_DV) begin
          if (rx_op != OP_NONE) begin
            op_d       = rx_op;
            byte_cnt_d = '0;
            to_cnt_d   = '0;
          end else begin
            err_opcode_d = 1'b1;
          end
        end
      end
      ST_ADDR: begin
        if (bus.i_Rx_DV) begin
          addr_d     = {addr_q[ADDR_W-9:0], bus.i_Rx_Byte};
          // Wraps to zero after the last address byte, ready for the data field.
          byte_cnt_d = (byte_cnt_q == ADDR_LAST) ? '0 : byte_cnt_q + 1'b1;
          to_cnt_d   = '0;
        end else if (to_expired) begin
          err_timeout_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (bus.i_Rx_DV) begin
          data_d     = {data_q[DATA_W-9:0], bus.i_Rx_Byte};
          byte_cnt_d = (byte_cnt_q == DATA_LAST) ? '0 : byte_cnt_q + 1'b1;
          to_cnt_d   = '0;
        end else if (to_expired) begin
          err_timeout_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ST_ISSUE: begin
        // Byte is dropped, command stays intact, even in the handshake cycle.
        if (bus.i_Rx_DV) begin
          err_overrun_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ---- datapath / error registers ----
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      op_q          <= OP_NONE;
      addr_q        <= '0;
      data_q        <= '0;
      byte_cnt_q    <= '0;
      to_cnt_q      <= '0;
      err_opcode_q  <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      op_q          <= op_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      byte_cnt_q    <= byte_cnt_d;
      to_cnt_q      <= to_cnt_d;
      err_opcode_q  <= err_opcode_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign bus.o_Cmd_Valid   = (state_q == ST_ISSUE);
  assign bus.o_Busy        = (state_q != ST_IDLE);
  assign bus.o_Cmd_Op      = op_q;
  assign bus.o_Cmd_Addr    = addr_q;
  assign bus.o_Cmd_Data    = data_q;
  assign bus.o_Err_Opcode  = err_opcode_q;
  assign bus.o_Err_Timeout = err_timeout_q;
  assign bus.o_Err_Overrun = err_overrun_q;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_sequencer
// Directed table of one-cycle vectors (inputs driven on the falling edge,
// outputs checked 1 ns after the following rising edge), followed by a
// hand-written reset-abort sequence. TIMEOUT_CLKS is 16.
// -----------------------------------------------------------------------------
module tb_uart_cmd_sequencer;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  uart_cmd_sequencer_if bus_if ();

  uart_cmd_sequencer #(.TIMEOUT_CLKS(16)) dut (
    .i_Clock   (clk),
    .i_Reset_n (rst_n),
    .bus       (bus_if)
  );

  typedef struct {
    logic        dv;
    logic [7:0]  rx_byte;
    logic        rdy;
    logic        e_valid;
    logic [2:0]  e_op;
    logic        e_busy;
    logic [2:0]  e_err;    // {opcode, timeout, overrun}
    logic        chk_ad;   // compare address/data on this vector
    logic [31:0] e_addr;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic void add(logic dv, logic [7:0] b, logic rdy, logic ev,
                              logic [2:0] eop, logic ebusy, logic [2:0] eerr,
                              logic chk = 1'b0, logic [31:0] ea = '0,
                              logic [31:0] ed = '0);
    vec_t v;
    v.dv = dv; v.rx_byte = b; v.rdy = rdy; v.e_valid = ev; v.e_op = eop;
    v.e_busy = ebusy; v.e_err = eerr; v.chk_ad = chk; v.e_addr = ea;
    v.e_data = ed;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic dv, input logic [7:0] b, input logic rdy);
    @(negedge clk);
    bus_if.i_Rx_DV     = dv;
    bus_if.i_Rx_Byte   = b;
    bus_if.i_Cmd_Ready = rdy;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] errs();
    return {bus_if.o_Err_Opcode, bus_if.o_Err_Timeout, bus_if.o_Err_Overrun};
  endfunction

  initial begin
    // MEM_WR 0x00001000 <- 0xDEADBEEF, ready high
    add(1, 8'h04, 1, 0, 4, 1, 3'b000);
    add(1, 8'h00, 1, 0, 4, 1, 3'b000);
    add(1, 8'h00, 1, 0, 4, 1, 3'b000);
    add(1, 8'h10, 1, 0, 4, 1, 3'b000);
    add(1, 8'h00, 1, 0, 4, 1, 3'b000);
    add(1, 8'hDE, 1, 0, 4, 1, 3'b000);
    add(1, 8'hAD, 1, 0, 4, 1, 3'b000);
    add(1, 8'hBE, 1, 0, 4, 1, 3'b000);
    add(1, 8'hEF, 1, 1, 4, 1, 3'b000, 1, 32'h0000_1000, 32'hDEAD_BEEF);
    add(0, 8'h00, 1, 0, 4, 0, 3'b000, 1, 32'h0000_1000, 32'hDEAD_BEEF);
    add(0, 8'h00, 1, 0, 4, 0, 3'b000);
    // PAUSE held 20 cycles by ready low; addr/data not cleared
    add(1, 8'h01, 0, 1, 1, 1, 3'b000, 1, 32'h0000_1000, 32'hDEAD_BEEF);
    for (int i = 0; i < 19; i++) add(0, 8'h00, 0, 1, 1, 1, 3'b000);
    add(0, 8'h00, 1, 0, 1, 0, 3'b000);
    add(0, 8'h00, 0, 0, 1, 0, 3'b000);
    // MEM_RD with a byte arriving exactly in the expiry cycle
    add(1, 8'h03, 0, 0, 3, 1, 3'b000);
    for (int i = 0; i < 15; i++) add(0, 8'h00, 0, 0, 3, 1, 3'b000);
    add(1, 8'h11, 0, 0, 3, 1, 3'b000);
    add(1, 8'h22, 0, 0, 3, 1, 3'b000);
    add(1, 8'h33, 0, 0, 3, 1, 3'b000);
    add(1, 8'h44, 0, 1, 3, 1, 3'b000, 1, 32'h1122_3344, 32'hDEAD_BEEF);
    add(0, 8'h00, 1, 0, 3, 0, 3'b000);
    // MEM_RD abandoned after two address bytes
    add(1, 8'h03, 0, 0, 3, 1, 3'b000);
    add(1, 8'h12, 0, 0, 3, 1, 3'b000);
    add(1, 8'h34, 0, 0, 3, 1, 3'b000);
    for (int i = 0; i < 15; i++) add(0, 8'h00, 0, 0, 3, 1, 3'b000);
    add(0, 8'h00, 0, 0, 3, 0, 3'b010);
    add(0, 8'h00, 0, 0, 3, 0, 3'b000);
    // REG_RD 0xAABBCCDD
    add(1, 8'h05, 1, 0, 5, 1, 3'b000);
    add(1, 8'hAA, 1, 0, 5, 1, 3'b000);
    add(1, 8'hBB, 1, 0, 5, 1, 3'b000);
    add(1, 8'hCC, 1, 0, 5, 1, 3'b000);
    add(1, 8'hDD, 1, 1, 5, 1, 3'b000, 1, 32'hAABB_CCDD, 32'hDEAD_BEEF);
    add(0, 8'h00, 1, 0, 5, 0, 3'b000);
    // unknown opcodes, then RESUME
    add(1, 8'h55, 1, 0, 5, 0, 3'b100);
    add(0, 8'h00, 1, 0, 5, 0, 3'b000);
    add(1, 8'h02, 1, 1, 2, 1, 3'b000);
    add(0, 8'h00, 1, 0, 2, 0, 3'b000);
    add(1, 8'h00, 1, 0, 2, 0, 3'b100);
    add(1, 8'h08, 1, 0, 2, 0, 3'b100);
    add(0, 8'h00, 1, 0, 2, 0, 3'b000);
    // MCU_RST with overrun while stalled, then overrun in the handshake cycle
    add(1, 8'h07, 0, 1, 7, 1, 3'b000);
    add(1, 8'h99, 0, 1, 7, 1, 3'b001, 1, 32'hAABB_CCDD, 32'hDEAD_BEEF);
    add(0, 8'h00, 0, 1, 7, 1, 3'b000);
    add(0, 8'h00, 1, 0, 7, 0, 3'b000);
    add(1, 8'h07, 1, 1, 7, 1, 3'b000);
    add(1, 8'hAB, 1, 0, 7, 0, 3'b001);
    add(0, 8'h00, 1, 0, 7, 0, 3'b000);

    // reset state
    rst_n = 1'b0;
    bus_if.i_Rx_DV = 1'b0;
    bus_if.i_Rx_Byte = 8'h00;
    bus_if.i_Cmd_Ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus_if.o_Cmd_Valid), 0);
    check("rst_busy",  32'(bus_if.o_Busy), 0);
    check("rst_op",    32'(bus_if.o_Cmd_Op), 0);
    check("rst_addr",  bus_if.o_Cmd_Addr, 0);
    check("rst_data",  bus_if.o_Cmd_Data, 0);
    check("rst_err",   32'(errs()), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].dv, vecs[i].rx_byte, vecs[i].rdy);
      check($sformatf("v%0d_valid", i), 32'(bus_if.o_Cmd_Valid), 32'(vecs[i].e_valid));
      check($sformatf("v%0d_op", i),    32'(bus_if.o_Cmd_Op),    32'(vecs[i].e_op));
      check($sformatf("v%0d_busy", i),  32'(bus_if.o_Busy),      32'(vecs[i].e_busy));
      check($sformatf("v%0d_err", i),   32'(errs()),             32'(vecs[i].e_err));
      if (vecs[i].chk_ad) begin
        check($sformatf("v%0d_addr", i), bus_if.o_Cmd_Addr, vecs[i].e_addr);
        check($sformatf("v%0d_data", i), bus_if.o_Cmd_Data, vecs[i].e_data);
      end
    end

    // reset in the middle of a MEM_WR address field
    step(1, 8'h04, 1);
    step(1, 8'h12, 1);
    step(1, 8'h34, 1);
    check("mid_busy", 32'(bus_if.o_Busy), 1);
    @(negedge clk);
    rst_n = 1'b0;
    bus_if.i_Rx_DV = 1'b0;
    @(posedge clk);
    #1;
    check("abort_valid", 32'(bus_if.o_Cmd_Valid), 0);
    check("abort_busy",  32'(bus_if.o_Busy), 0);
    check("abort_op",    32'(bus_if.o_Cmd_Op), 0);
    check("abort_addr",  bus_if.o_Cmd_Addr, 0);
    check("abort_data",  bus_if.o_Cmd_Data, 0);
    check("abort_err",   32'(errs()), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 8'h00, 1);
    check("post_abort_busy", 32'(bus_if.o_Busy), 0);
    check("post_abort_err",  32'(errs()), 0);

    // fresh REG_WR frame
    step(1, 8'h06, 1);
    for (int i = 1; i <= 7; i++) begin
      step(1, 8'(i), 1);
      check($sformatf("regwr_b%0d_valid", i), 32'(bus_if.o_Cmd_Valid), 0);
    end
    step(1, 8'h08, 1);
    check("regwr_valid", 32'(bus_if.o_Cmd_Valid), 1);
    check("regwr_op",    32'(bus_if.o_Cmd_Op), 6);
    check("regwr_addr",  bus_if.o_Cmd_Addr, 32'h0102_0304);
    check("regwr_data",  bus_if.o_Cmd_Data, 32'h0506_0708);
    check("regwr_err",   32'(errs()), 0);
    step(0, 8'h00, 1);
    check("regwr_done_valid", 32'(bus_if.o_Cmd_Valid), 0);
    check("regwr_done_busy",  32'(bus_if.o_Busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
